// File: rtl/lelo_temp_pkg.sv
// Shared constants and helpers for the temperature oscillator measurement block.
// Pure package: no latency, no flow control.
package lelo_temp_pkg;

    localparam int DELTA_W           = 8;
    localparam int WINDOW_CYCLES_DEF = 32;

    function automatic logic [DELTA_W-1:0] sat_add(input logic [DELTA_W-1:0] a,
                                                   input logic               inc);
        logic [DELTA_W:0] sum;
        sum = {1'b0, a} + {{DELTA_W{1'b0}}, inc};
        return sum[DELTA_W] ? {DELTA_W{1'b1}} : sum[DELTA_W-1:0];
    endfunction

endpackage

// File: rtl/ana_edge_sync.sv
// Synchronizes the asynchronous oscillator and emits a one-cycle rising-edge pulse.
// Latency: pulse visible after SYNC_STAGES lf_clk edges; no backpressure (free-running).
module ana_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic lf_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge lf_clk) begin
        if (rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/temp_osc_measure.sv
// Counts oscillator rising edges over WINDOW_CYCLES lf_clk cycles into a saturating delta.
// Latency: delta_valid on the window-closing edge; no backpressure, results are strobed out.
module temp_osc_measure
    import lelo_temp_pkg::*;
#(
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic               lf_clk,
    input  logic               rst_n,
    input  logic               ana_clk,
    input  logic               ana_en,
    output logic [DELTA_W-1:0] delta,
    output logic               delta_valid
);

    localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic               ana_edge;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [WIN_W-1:0]   win_cnt_d;
    logic [DELTA_W-1:0] edge_cnt_q;
    logic [DELTA_W-1:0] edge_cnt_d;
    logic [DELTA_W-1:0] delta_q;
    logic [DELTA_W-1:0] delta_d;
    logic               delta_valid_q;
    logic               delta_valid_d;

    ana_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .lf_clk     (lf_clk),
        .rst_n      (rst_n),
        .async_in   (ana_clk),
        .edge_pulse (ana_edge)
    );

    always_comb begin
        win_cnt_d     = '0;
        edge_cnt_d    = '0;
        delta_d       = delta_q;
        delta_valid_d = 1'b0;
        if (ana_en) begin
            if (win_cnt_q == WIN_LAST) begin
                // An edge arriving on the closing cycle belongs to the closing window.
                delta_d       = sat_add(edge_cnt_q, ana_edge);
                delta_valid_d = 1'b1;
            end else begin
                win_cnt_d  = win_cnt_q + WIN_W'(1);
                edge_cnt_d = sat_add(edge_cnt_q, ana_edge);
            end
        end
    end

    always_ff @(posedge lf_clk) begin
        if (rst_n) begin
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            delta_q       <= '0;
            delta_valid_q <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            delta_q       <= delta_d;
            delta_valid_q <= delta_valid_d;
        end
    end

    assign delta       = delta_q;
    assign delta_valid = delta_valid_q;

endmodule

// File: tb/tb_temp_osc_measure.sv
// Scoreboard bench for temp_osc_measure: a 32-cycle instance for most scenarios and a
// 1024-cycle instance for saturation; expected deltas are queued before each window.
module tb_temp_osc_measure;

    logic       lf_clk;
    logic       rst_n;
    logic       ana_clk;
    logic       ana_en;
    logic       ana_en_sat;
    logic [7:0] delta;
    logic       delta_valid;
    logic [7:0] delta_sat;
    logic       delta_valid_sat;

    int   checks = 0;
    int   errors = 0;
    int   osc_period = 0;
    int   osc_phase = 0;
    logic osc_level = 1'b0;

    typedef struct {
        int lo;
        int hi;
    } exp_t;
    exp_t sb_q[$];

    temp_osc_measure #(.WINDOW_CYCLES(32), .SYNC_STAGES(2)) dut (
        .lf_clk      (lf_clk),
        .rst_n       (rst_n),
        .ana_clk     (ana_clk),
        .ana_en      (ana_en),
        .delta       (delta),
        .delta_valid (delta_valid)
    );

    temp_osc_measure #(.WINDOW_CYCLES(1024), .SYNC_STAGES(2)) dut_sat (
        .lf_clk      (lf_clk),
        .rst_n       (rst_n),
        .ana_clk     (ana_clk),
        .ana_en      (ana_en_sat),
        .delta       (delta_sat),
        .delta_valid (delta_valid_sat)
    );

    initial begin
        lf_clk = 1'b0;
        forever #5 lf_clk = ~lf_clk;
    end

    // Oscillator model: changes only on falling lf_clk edges, high for half its period.
    initial begin
        ana_clk = 1'b0;
        forever begin
            @(negedge lf_clk);
            if (osc_period > 0) begin
                osc_phase = (osc_phase + 1) % osc_period;
                ana_clk   = (osc_phase < osc_period / 2);
            end else begin
                ana_clk = osc_level;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge lf_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits (bounded) for the next strobe; reports cycles taken and whether delta moved early.
    task automatic wait_pulse(input int max_cyc, input bit sat,
                              output int n, output bit found, output bit stable);
        logic [7:0] d0;
        d0     = sat ? delta_sat : delta;
        n      = 0;
        found  = 1'b0;
        stable = 1'b1;
        while (!found && n < max_cyc) begin
            tick();
            n++;
            if (sat ? delta_valid_sat : delta_valid) found = 1'b1;
            else if ((sat ? delta_sat : delta) !== d0) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n; bit found, stable; exp_t e;
        rst_n = 1'b1; ana_en = 1'b1; ana_en_sat = 1'b0; osc_period = 4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({delta, delta_valid} !== 9'h0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got delta=%0d vld=%b want 0/0", i, delta, delta_valid);
            end
        end
        rst_n = 1'b0;
        sb_q.push_back('{7, 9});
        wait_pulse(40, 1'b0, n, found, stable);
        checks++;
        if (!found || n != 32) begin
            errors++;
            $display("FAIL reset_first_pulse got %0d cycles (found=%b) want 32", n, found);
        end
        e = sb_q.pop_front();
        checks++;
        if (int'(delta) < e.lo || int'(delta) > e.hi) begin
            errors++;
            $display("FAIL reset_first_delta got %0d want %0d..%0d", delta, e.lo, e.hi);
        end
        checks++;
        if ({delta_sat, delta_valid_sat} !== 9'h0) begin
            errors++;
            $display("FAIL reset_sat_idle got delta=%0d vld=%b want 0/0", delta_sat, delta_valid_sat);
        end
    endtask

    task automatic test_nominal();
        int n; bit found, stable; exp_t e; int exp_n;
        exp_n = 32;
        for (int w = 0; w < 3; w++) begin
            sb_q.push_back('{8, 8});
            wait_pulse(40, 1'b0, n, found, stable);
            checks++;
            if (!found || n != exp_n) begin
                errors++;
                $display("FAIL nominal_spacing w%0d got %0d want %0d", w, n, exp_n);
            end
            e = sb_q.pop_front();
            checks++;
            if (int'(delta) < e.lo || int'(delta) > e.hi || !stable) begin
                errors++;
                $display("FAIL nominal_delta w%0d got %0d stable=%b want %0d", w, delta, stable, e.lo);
            end
            tick();
            checks++;
            if (delta_valid !== 1'b0) begin
                errors++;
                $display("FAIL nominal_width w%0d got vld=%b want 0", w, delta_valid);
            end
            exp_n = 31;
        end
    endtask

    task automatic test_static();
        int n; bit found, stable; exp_t e; int exp_n;
        exp_n = 31;
        osc_period = 0;
        for (int lv = 0; lv < 2; lv++) begin
            osc_level = lv[0];
            sb_q.push_back('{0, 9});
            sb_q.push_back('{0, 0});
            sb_q.push_back('{0, 0});
            for (int w = 0; w < 3; w++) begin
                wait_pulse(40, 1'b0, n, found, stable);
                checks++;
                if (!found || n != exp_n) begin
                    errors++;
                    $display("FAIL static_spacing lv%0d w%0d got %0d want %0d", lv, w, n, exp_n);
                end
                e = sb_q.pop_front();
                checks++;
                if (int'(delta) < e.lo || int'(delta) > e.hi) begin
                    errors++;
                    $display("FAIL static_delta lv%0d w%0d got %0d want %0d..%0d", lv, w, delta, e.lo, e.hi);
                end
                exp_n = 32;
            end
        end
    endtask

    // A rise first sampled on window offset 30 is counted on the closing edge (offset 32);
    // one sampled on offset 31 is counted one edge later, in the next window.
    task automatic test_edge_latency();
        int n; bit found, stable; exp_t e;
        int pre_ticks[2] = '{29, 30};
        int exp_n[4]     = '{3, 32, 2, 32};
        int exp_d[4]     = '{1, 0, 0, 1};
        osc_level = 1'b0;
        sb_q.push_back('{0, 0});
        wait_pulse(40, 1'b0, n, found, stable);
        e = sb_q.pop_front();
        checks++;
        if (!found || delta !== 8'd0) begin
            errors++;
            $display("FAIL latency_settle got %0d want 0", delta);
        end
        for (int c = 0; c < 2; c++) begin
            ticks(pre_ticks[c]);
            osc_level = 1'b1;
            for (int w = 0; w < 2; w++) begin
                sb_q.push_back('{exp_d[2*c+w], exp_d[2*c+w]});
                wait_pulse(40, 1'b0, n, found, stable);
                if (c == 0) osc_level = 1'b0;
                checks++;
                if (!found || n != exp_n[2*c+w]) begin
                    errors++;
                    $display("FAIL latency_spacing c%0d w%0d got %0d want %0d", c, w, n, exp_n[2*c+w]);
                end
                e = sb_q.pop_front();
                checks++;
                if (int'(delta) != e.lo) begin
                    errors++;
                    $display("FAIL latency_delta c%0d w%0d got %0d want %0d", c, w, delta, e.lo);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int n; bit found, stable; exp_t e; bit saw_vld; bit moved;
        osc_period = 4;
        sb_q.push_back('{0, 9});
        sb_q.push_back('{8, 8});
        for (int w = 0; w < 2; w++) begin
            wait_pulse(40, 1'b0, n, found, stable);
            e = sb_q.pop_front();
            checks++;
            if (!found || int'(delta) < e.lo || int'(delta) > e.hi) begin
                errors++;
                $display("FAIL drop_prewindow w%0d got %0d want %0d..%0d", w, delta, e.lo, e.hi);
            end
        end
        ticks(19);
        ana_en  = 1'b0;
        saw_vld = 1'b0;
        moved   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (delta_valid) saw_vld = 1'b1;
            if (delta !== 8'd8) moved = 1'b1;
        end
        checks++;
        if (saw_vld) begin
            errors++;
            $display("FAIL drop_no_pulse got a strobe while disabled want none");
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL drop_delta_hold got %0d want 8", delta);
        end
        ana_en = 1'b1;
        sb_q.push_back('{7, 9});
        sb_q.push_back('{8, 8});
        for (int w = 0; w < 2; w++) begin
            wait_pulse(40, 1'b0, n, found, stable);
            checks++;
            if (!found || n != 32) begin
                errors++;
                $display("FAIL drop_reenable_spacing w%0d got %0d want 32", w, n);
            end
            e = sb_q.pop_front();
            checks++;
            if (int'(delta) < e.lo || int'(delta) > e.hi) begin
                errors++;
                $display("FAIL drop_reenable_delta w%0d got %0d want %0d..%0d", w, delta, e.lo, e.hi);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n; bit found, stable; exp_t e;
        ticks(14);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({delta, delta_valid} !== 9'h0) begin
            errors++;
            $display("FAIL midreset_clear got delta=%0d vld=%b want 0/0", delta, delta_valid);
        end
        tick();
        rst_n = 1'b0;
        sb_q.push_back('{7, 9});
        sb_q.push_back('{8, 8});
        for (int w = 0; w < 2; w++) begin
            wait_pulse(40, 1'b0, n, found, stable);
            checks++;
            if (!found || n != 32) begin
                errors++;
                $display("FAIL midreset_spacing w%0d got %0d want 32", w, n);
            end
            e = sb_q.pop_front();
            checks++;
            if (int'(delta) < e.lo || int'(delta) > e.hi) begin
                errors++;
                $display("FAIL midreset_delta w%0d got %0d want %0d..%0d", w, delta, e.lo, e.hi);
            end
        end
    endtask

    task automatic test_saturation();
        int n; bit found, stable; exp_t e;
        ana_en     = 1'b0;
        osc_period = 2;
        ana_en_sat = 1'b1;
        for (int w = 0; w < 2; w++) begin
            sb_q.push_back('{255, 255});
            wait_pulse(1100, 1'b1, n, found, stable);
            checks++;
            if (!found || n != 1024) begin
                errors++;
                $display("FAIL sat_spacing w%0d got %0d want 1024", w, n);
            end
            e = sb_q.pop_front();
            checks++;
            if (int'(delta_sat) != e.lo) begin
                errors++;
                $display("FAIL sat_delta w%0d got %0d want %0d", w, delta_sat, e.lo);
            end
        end
        ana_en_sat = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; ana_en = 1'b0; ana_en_sat = 1'b0;
        test_reset();
        test_nominal();
        test_static();
        test_edge_latency();
        test_enable_drop();
        test_mid_reset();
        test_saturation();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_osc_measure.md
# temp_osc_measure

Frequency-to-digital converter for the temperature-dependent ring oscillator. It counts rising edges of the analog oscillator output over a fixed window of low-frequency clock cycles and publishes the count as an 8-bit `delta` with a one-cycle `delta_valid` strobe. It sits beside the analog temperature sensor macro and runs entirely in the 32768 Hz real-time-clock domain. The oscillator output is treated as an asynchronous data input, not as a clock.

## Interface
- `WINDOW_CYCLES`, default 32: measurement window length in `lf_clk` cycles; must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer depth for `ana_clk`; must be ≥ 2.
- `lf_clk` input 1: the single clock (32768 Hz RTC); all flops on its rising edge.
- `rst_n` input 1: reset, synchronous and active-high. The name is kept for consistency with the surrounding design; asserting it high resets the block.
- `ana_clk` input 1: oscillator output; asynchronous to `lf_clk`.
- `ana_en` input 1: measurement enable; synchronous to `lf_clk`.
- `delta` output 8: edge count of the last completed window, saturating.
- `delta_valid` output 1: one-cycle pulse when `delta` is updated.

## Operation
- **Synchronizer and edge detect**
  - `ana_clk` passes through a `SYNC_STAGES` flop chain, then one history flop.
  - A rising edge (`edge`) is detected as synchronized = 1 and history = 0.
- **Counters**
  - Window counter `win_cnt`: width $clog2(WINDOW_CYCLES), counts 0 … WINDOW_CYCLES−1.
  - Edge counter `edge_cnt`: 8 bits, saturates at 255 and never wraps.
- **While `ana_en` = 1**
  - Each cycle: `win_cnt` increments, and `edge_cnt` increments (saturating) if `edge` is set.
  - On the cycle where `win_cnt` = WINDOW_CYCLES−1:
    - `delta` <= sat255(`edge_cnt` + `edge`).
    - `delta_valid` <= 1.
    - `edge_cnt` <= 0 and `win_cnt` <= 0.
    - An edge in this cycle belongs to the closing window.
- **While `ana_en` = 0**
  - `win_cnt` and `edge_cnt` are held at 0.
  - `delta_valid` = 0 and `delta` holds its last value.
  - The synchronizer keeps running.
- **`ana_en` deasserted mid-window**: the partial window is discarded; no `delta_valid` is issued.
- **Reset**: every flop clears to 0, including the synchronizer, `delta` (0) and `delta_valid` (0). Reset has priority over `ana_en`.
- **Resolution**: ideal `delta` = f_ana × WINDOW_CYCLES / 32768.
  - The count is correct only while f_ana < f_lf/2.
  - Each high and low phase of `ana_clk` must exceed one `lf_clk` period.
  - Faster input aliases. This is a system constraint, not detected in RTL.

## Timing
- `delta_valid` is high for exactly one cycle, asserted on the clock edge that closes the window.
- While enabled, pulses repeat every WINDOW_CYCLES cycles.
- First pulse after `ana_en` rises (or after reset release with `ana_en` = 1): exactly WINDOW_CYCLES cycles after the first enabled cycle.
- `delta` changes only on the same edge that asserts `delta_valid`, and is stable for the following WINDOW_CYCLES−1 cycles.
- Edge latency: an `ana_clk` rising edge is counted SYNC_STAGES+1 `lf_clk` edges after capture. Edges still in the pipeline at window close are counted in the next window; no edge is lost or double-counted.
- Edges in the pipeline when `ana_en` rises are counted if they emerge on an enabled cycle.

## Structure
- Shared package `lelo_temp_pkg` holds:
  - `DELTA_W` = 8.
  - Default `WINDOW_CYCLES`.
  - A saturating-add helper function.
- One sub-module, `ana_edge_sync`:
  - Parameter `SYNC_STAGES`.
  - Inputs: `lf_clk`, `rst_n`, async input.
  - Output: single-cycle rising-edge pulse.
- Window and edge counters and the output register live in `temp_osc_measure`.

## Test plan
1. **Reset**: hold `rst_n` = 1 for 3 cycles while `ana_clk` toggles → `delta` = 0 and `delta_valid` = 0 throughout. Release → no pulse before 32 enabled cycles.
2. **Nominal count**: `ana_en` = 1, `ana_clk` period 4 `lf_clk` cycles, WINDOW_CYCLES = 32 → `delta` = 8 in every window (±1 only on the first window). `delta_valid` pulses exactly 32 cycles apart, each 1 cycle wide.
3. **Static oscillator**: `ana_clk` held at 0 or 1 → `delta` = 0, pulses continue every 32 cycles.
4. **Saturation**: WINDOW_CYCLES = 1024, `ana_clk` period 2 cycles (512 edges) → `delta` = 255, no wrap.
5. **Enable drop**: drop `ana_en` at cycle 20 of a window after a window with `delta` = 8 → no pulse and `delta` stays 8. Re-enable → first pulse exactly 32 cycles later.
6. **Mid-window reset**: assert `rst_n` = 1 at cycle 15 → `delta` = 0 on the next edge. After release, the next pulse comes 32 enabled cycles later with the correct count.
